// File: rtl/vga_ram_arbiter.sv
// Cellular-RAM (async SRAM mode) arbiter between the display read port and the draw write port.
// One access per ACCESS_CYCLES+RECOVERY_CYCLES+1 clocks; requesters hold req until ack, writes win after STARVE_LIMIT reads.
module vga_ram_arbiter #(
  parameter int ADDR_W          = 26,
  parameter int DATA_W          = 16,
  parameter int ACCESS_CYCLES   = 2,
  parameter int RECOVERY_CYCLES = 1,
  parameter int STARVE_LIMIT    = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ack,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  output logic              busy,
  output logic [ADDR_W-1:0] MemAdr,
  input  logic [DATA_W-1:0] mem_dq_in,
  output logic [DATA_W-1:0] mem_dq_out,
  output logic              mem_dq_oe,
  output logic              MemOE,
  output logic              MemWR,
  output logic              RamCS
);

  localparam int WAIT_W = $clog2(ACCESS_CYCLES + 1);
  localparam int REC_W  = $clog2(RECOVERY_CYCLES + 1);
  localparam int STV_W  = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, RD_ACC, WR_ACC, RECOVER} state_t;

  state_t              state_q, state_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [REC_W-1:0]    rec_q, rec_d;
  logic [STV_W-1:0]    starve_q, starve_d;
  logic [ADDR_W-1:0]   adr_q, adr_d;
  logic [DATA_W-1:0]   dq_out_q, dq_out_d;
  logic                dq_oe_q, dq_oe_d;
  logic                oe_n_q, oe_n_d;
  logic                we_n_q, we_n_d;
  logic                cs_n_q, cs_n_d;
  logic                rd_ack_q, rd_ack_d;
  logic                wr_ack_q, wr_ack_d;
  logic                rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic                busy_q, busy_d;
  logic                grant_wr;

  assign grant_wr = wr_req && (!rd_req || (starve_q == STV_W'(STARVE_LIMIT)));

  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    rec_d      = rec_q;
    starve_d   = starve_q;
    adr_d      = adr_q;
    dq_out_d   = dq_out_q;
    dq_oe_d    = dq_oe_q;
    oe_n_d     = oe_n_q;
    we_n_d     = we_n_q;
    cs_n_d     = cs_n_q;
    rd_data_d  = rd_data_q;
    rd_ack_d   = 1'b0;
    wr_ack_d   = 1'b0;
    rd_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (grant_wr) begin
          state_d  = WR_ACC;
          adr_d    = wr_addr;
          dq_out_d = wr_data;
          dq_oe_d  = 1'b1;
          we_n_d   = 1'b0;
          cs_n_d   = 1'b0;
          wr_ack_d = 1'b1;
          wait_d   = WAIT_W'(ACCESS_CYCLES - 1);
          starve_d = '0;
        end else if (rd_req) begin
          state_d  = RD_ACC;
          adr_d    = rd_addr;
          oe_n_d   = 1'b0;
          cs_n_d   = 1'b0;
          rd_ack_d = 1'b1;
          wait_d   = WAIT_W'(ACCESS_CYCLES - 1);
          // Count reads that bypass a waiting write; saturate so the write wins next.
          if (!wr_req)
            starve_d = '0;
          else if (starve_q != STV_W'(STARVE_LIMIT))
            starve_d = starve_q + STV_W'(1);
        end else begin
          starve_d = '0;
        end
      end

      RD_ACC: begin
        if (wait_q == '0) begin
          rd_data_d  = mem_dq_in;
          rd_valid_d = 1'b1;
          oe_n_d     = 1'b1;
          cs_n_d     = 1'b1;
          rec_d      = REC_W'(RECOVERY_CYCLES - 1);
          state_d    = RECOVER;
        end else begin
          wait_d = wait_q - WAIT_W'(1);
        end
      end

      WR_ACC: begin
        // Bus drive is kept on into the first recovery cycle for data hold after WE# rises.
        if (wait_q == '0) begin
          we_n_d  = 1'b1;
          cs_n_d  = 1'b1;
          rec_d   = REC_W'(RECOVERY_CYCLES - 1);
          state_d = RECOVER;
        end else begin
          wait_d = wait_q - WAIT_W'(1);
        end
      end

      RECOVER: begin
        dq_oe_d  = 1'b0;
        dq_out_d = '0;
        if (rec_q == '0)
          state_d = IDLE;
        else
          rec_d = rec_q - REC_W'(1);
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= IDLE;
      wait_q     <= '0;
      rec_q      <= '0;
      starve_q   <= '0;
      adr_q      <= '0;
      dq_out_q   <= '0;
      dq_oe_q    <= 1'b0;
      oe_n_q     <= 1'b1;
      we_n_q     <= 1'b1;
      cs_n_q     <= 1'b1;
      rd_ack_q   <= 1'b0;
      wr_ack_q   <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      rec_q      <= rec_d;
      starve_q   <= starve_d;
      adr_q      <= adr_d;
      dq_out_q   <= dq_out_d;
      dq_oe_q    <= dq_oe_d;
      oe_n_q     <= oe_n_d;
      we_n_q     <= we_n_d;
      cs_n_q     <= cs_n_d;
      rd_ack_q   <= rd_ack_d;
      wr_ack_q   <= wr_ack_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      busy_q     <= busy_d;
    end
  end

  assign rd_ack     = rd_ack_q;
  assign wr_ack     = wr_ack_q;
  assign rd_valid   = rd_valid_q;
  assign rd_data    = rd_data_q;
  assign busy       = busy_q;
  assign MemAdr     = adr_q;
  assign mem_dq_out = dq_out_q;
  assign mem_dq_oe  = dq_oe_q;
  assign MemOE      = oe_n_q;
  assign MemWR      = we_n_q;
  assign RamCS      = cs_n_q;

endmodule

// File: tb/tb_vga_ram_arbiter.sv
// Bench for vga_ram_arbiter: transaction-level reference model with per-cycle compare,
// directed literal checks, randomized traffic, and a short-access instance.
module tb_vga_ram_arbiter;
  localparam int A  = 2;
  localparam int R  = 1;
  localparam int SL = 4;

  logic        clk;
  logic        resetn;
  logic        rd_req, wr_req;
  logic [25:0] rd_addr, wr_addr;
  logic [15:0] wr_data;
  logic        rd_ack, rd_valid, wr_ack, busy;
  logic [15:0] rd_data;
  logic [25:0] MemAdr;
  logic [15:0] mem_dq_in, mem_dq_out;
  logic        mem_dq_oe, MemOE, MemWR, RamCS;

  logic        rd_req2, wr_req2;
  logic [25:0] rd_addr2, wr_addr2;
  logic [15:0] wr_data2;
  logic        rd_ack2, rd_valid2, wr_ack2, busy2;
  logic [15:0] rd_data2;
  logic [25:0] MemAdr2;
  logic [15:0] mem_dq_in2, mem_dq_out2;
  logic        mem_dq_oe2, MemOE2, MemWR2, RamCS2;

  int compared   = 0;
  int mismatched = 0;

  logic [15:0] sram [256];

  vga_ram_arbiter dut (
    .clk(clk), .resetn(resetn),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_valid(rd_valid), .rd_data(rd_data),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack), .busy(busy),
    .MemAdr(MemAdr), .mem_dq_in(mem_dq_in), .mem_dq_out(mem_dq_out), .mem_dq_oe(mem_dq_oe),
    .MemOE(MemOE), .MemWR(MemWR), .RamCS(RamCS)
  );

  vga_ram_arbiter #(.ACCESS_CYCLES(1), .RECOVERY_CYCLES(2)) dut2 (
    .clk(clk), .resetn(resetn),
    .rd_req(rd_req2), .rd_addr(rd_addr2), .rd_ack(rd_ack2), .rd_valid(rd_valid2), .rd_data(rd_data2),
    .wr_req(wr_req2), .wr_addr(wr_addr2), .wr_data(wr_data2), .wr_ack(wr_ack2), .busy(busy2),
    .MemAdr(MemAdr2), .mem_dq_in(mem_dq_in2), .mem_dq_out(mem_dq_out2), .mem_dq_oe(mem_dq_oe2),
    .MemOE(MemOE2), .MemWR(MemWR2), .RamCS(RamCS2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] init_val(int i);
    logic [15:0] v;
    v = 16'(i * 16'h0111) ^ 16'h3C3C;
    if (i == 0) v = 16'hA5C3;
    return v;
  endfunction

  // Async SRAM model: combinational read while CS#/OE# low, write on every strobed cycle.
  assign mem_dq_in  = (!RamCS && !MemOE) ? sram[MemAdr[7:0]] : 16'h0BAD;
  assign mem_dq_in2 = (!RamCS2 && !MemOE2) ? (MemAdr2[15:0] ^ 16'h5A5A) : 16'h0BAD;

  always @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < 256; i++) sram[i] <= init_val(i);
    end else if (!RamCS && !MemWR) begin
      sram[MemAdr[7:0]] <= mem_dq_out;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: m_t is the cycle number inside the current access (0 = idle).
  int          m_t = 0;
  int          m_kind = 0;   // 0 none, 1 read, 2 write
  int          m_starve = 0;
  logic [25:0] m_adr = '0;
  logic [15:0] m_data = '0;
  logic [15:0] m_rd_data = '0;
  logic [15:0] ref_mem [256];

  initial begin
    forever begin
      logic act;
      logic e_dqoe;
      @(posedge clk);
      #1;
      if (!resetn) begin
        m_t = 0; m_kind = 0; m_starve = 0; m_adr = '0; m_data = '0; m_rd_data = '0;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
      end else if (m_t == 0) begin
        if (wr_req && (!rd_req || m_starve == SL)) begin
          m_kind = 2; m_t = 1; m_adr = wr_addr; m_data = wr_data;
          ref_mem[wr_addr[7:0]] = wr_data;
          m_starve = 0;
        end else if (rd_req) begin
          m_kind = 1; m_t = 1; m_adr = rd_addr;
          m_starve = wr_req ? ((m_starve < SL) ? m_starve + 1 : SL) : 0;
        end else begin
          m_starve = 0;
        end
      end else begin
        m_t++;
        if (m_kind == 1 && m_t == A + 1) m_rd_data = ref_mem[m_adr[7:0]];
        if (m_t > A + R) begin m_t = 0; m_kind = 0; end
      end

      act    = (m_t >= 1 && m_t <= A);
      e_dqoe = (m_kind == 2 && m_t >= 1 && m_t <= A + 1);
      chk("busy",       32'(busy),       32'(m_t != 0));
      chk("rd_ack",     32'(rd_ack),     32'(m_kind == 1 && m_t == 1));
      chk("wr_ack",     32'(wr_ack),     32'(m_kind == 2 && m_t == 1));
      chk("RamCS",      32'(RamCS),      32'(!act));
      chk("MemOE",      32'(MemOE),      32'(!(act && m_kind == 1)));
      chk("MemWR",      32'(MemWR),      32'(!(act && m_kind == 2)));
      chk("mem_dq_oe",  32'(mem_dq_oe),  32'(e_dqoe));
      chk("mem_dq_out", 32'(mem_dq_out), 32'(e_dqoe ? m_data : 16'h0));
      chk("rd_valid",   32'(rd_valid),   32'(m_kind == 1 && m_t == A + 1));
      chk("rd_data",    32'(rd_data),    32'(m_rd_data));
      chk("MemAdr",     32'(MemAdr),     32'(m_adr));
      chk("oe_we_excl", 32'(!MemOE && !MemWR), 32'(0));
      chk("drive_oe_excl", 32'(mem_dq_oe && !MemOE), 32'(0));
    end
  end

  function automatic logic [25:0] rnd_addr();
    return {18'($urandom_range(0, 3)), 8'($urandom_range(0, 15))};
  endfunction

  task automatic wait_idle();
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!busy && !busy2) break;
    end
    chk("idle_timeout", 32'(busy), 32'(0));
  endtask

  int seq [10];
  int nacks;
  logic [25:0] acc2;

  initial begin
    resetn = 1'b0;
    rd_req = 0; wr_req = 0; rd_addr = '0; wr_addr = '0; wr_data = '0;
    rd_req2 = 0; wr_req2 = 0; rd_addr2 = '0; wr_addr2 = '0; wr_data2 = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", 32'(busy), 32'(0));
    chk("reset_cs", 32'(RamCS), 32'(1));
    chk("reset_adr", 32'(MemAdr), 32'(0));
    resetn = 1'b1;
    wait_idle();

    // Single read of 0x000100.
    rd_req = 1; rd_addr = 26'h000100;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      case (c)
        1: begin chk("t1_ack", 32'(rd_ack), 1); chk("t1_cs", 32'(RamCS), 0);
                 chk("t1_oe", 32'(MemOE), 0); chk("t1_adr", 32'(MemAdr), 32'h100); rd_req = 0; end
        2: begin chk("t1_ack2", 32'(rd_ack), 0); chk("t1_cs2", 32'(RamCS), 0);
                 chk("t1_oe2", 32'(MemOE), 0); chk("t1_adr2", 32'(MemAdr), 32'h100); end
        3: begin chk("t1_vld", 32'(rd_valid), 1); chk("t1_data", 32'(rd_data), 32'hA5C3);
                 chk("t1_cs3", 32'(RamCS), 1); chk("t1_adr3", 32'(MemAdr), 32'h100); end
        default: begin chk("t1_busy4", 32'(busy), 0); chk("t1_vld4", 32'(rd_valid), 0); end
      endcase
    end

    // Single write of 0x1234 to 0x0003FF.
    wr_req = 1; wr_addr = 26'h0003FF; wr_data = 16'h1234;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      chk("t2_oe", 32'(MemOE), 1);
      if (c <= 2) begin
        chk("t2_we", 32'(MemWR), 0); chk("t2_cs", 32'(RamCS), 0);
      end
      if (c <= 3) begin
        chk("t2_dqoe", 32'(mem_dq_oe), 1); chk("t2_dq", 32'(mem_dq_out), 32'h1234);
      end
      if (c == 1) begin chk("t2_ack", 32'(wr_ack), 1); wr_req = 0; end
      if (c == 3) chk("t2_we3", 32'(MemWR), 1);
      if (c == 4) begin chk("t2_dqoe4", 32'(mem_dq_oe), 0); chk("t2_busy4", 32'(busy), 0); end
    end

    // Simultaneous requests: read first, write acked in cycle 5.
    rd_req = 1; rd_addr = 26'h0003FF;
    wr_req = 1; wr_addr = 26'h00007F; wr_data = 16'hBEEF;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) begin chk("t3_rdack", 32'(rd_ack), 1); chk("t3_wrack1", 32'(wr_ack), 0); rd_req = 0; end
      if (c == 3) begin chk("t3_vld", 32'(rd_valid), 1); chk("t3_data", 32'(rd_data), 32'h1234); end
      if (c == 5) begin chk("t3_wrack", 32'(wr_ack), 1); chk("t3_adr", 32'(MemAdr), 32'h7F); wr_req = 0; end
    end
    rd_req = 1; rd_addr = 26'h00007F;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 1) rd_req = 0;
      if (c == 3) chk("t3_readback", 32'(rd_data), 32'hBEEF);
    end
    wait_idle();

    // Starvation: both held high; expect R R R R W R R R R W.
    rd_req = 1; rd_addr = rnd_addr(); wr_req = 1; wr_addr = rnd_addr(); wr_data = 16'($urandom);
    nacks = 0;
    for (int i = 0; i < 200 && nacks < 10; i++) begin
      @(negedge clk);
      if (rd_ack) begin seq[nacks] = 0; nacks++; rd_addr = rnd_addr(); end
      if (wr_ack) begin seq[nacks] = 1; nacks++; wr_addr = rnd_addr(); wr_data = 16'($urandom); end
    end
    chk("t4_acks", 32'(nacks), 32'd10);
    for (int i = 0; i < 10; i++) chk("t4_order", 32'(seq[i]), 32'(i == 4 || i == 9));
    rd_req = 0; wr_req = 0;
    wait_idle();

    // Reset during the second write-strobe cycle.
    wr_req = 1; wr_addr = 26'h000055; wr_data = 16'h6A6A;
    @(negedge clk); chk("t5_ack", 32'(wr_ack), 1);
    @(negedge clk); chk("t5_we", 32'(MemWR), 0); resetn = 0;
    @(negedge clk);
    chk("t5_we_rst", 32'(MemWR), 1); chk("t5_cs_rst", 32'(RamCS), 1);
    chk("t5_dqoe_rst", 32'(mem_dq_oe), 0); chk("t5_busy_rst", 32'(busy), 0);
    chk("t5_vld_rst", 32'(rd_valid), 0);
    resetn = 1;
    @(negedge clk); chk("t5_reack", 32'(wr_ack), 1); wr_req = 0;
    wait_idle();

    // Randomized traffic obeying the hold-until-ack handshake.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (rd_req && rd_ack) begin
        rd_req = 1'($urandom_range(0, 1)); rd_addr = rnd_addr();
      end else if (!rd_req && $urandom_range(0, 3) == 0) begin
        rd_req = 1; rd_addr = rnd_addr();
      end
      if (wr_req && wr_ack) begin
        wr_req = 1'($urandom_range(0, 1)); wr_addr = rnd_addr(); wr_data = 16'($urandom);
      end else if (!wr_req && $urandom_range(0, 4) == 0) begin
        wr_req = 1; wr_addr = rnd_addr(); wr_data = 16'($urandom);
      end
    end
    rd_req = 0; wr_req = 0;
    wait_idle();

    // Short-access instance: back-to-back reads every 4 cycles.
    rd_req2 = 1; rd_addr2 = 26'h000010; acc2 = '0;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      chk("t6_ack", 32'(rd_ack2), 32'(c % 4 == 1));
      chk("t6_cs", 32'(RamCS2), 32'(c % 4 != 1));
      chk("t6_oe", 32'(MemOE2), 32'(c % 4 != 1));
      chk("t6_vld", 32'(rd_valid2), 32'(c % 4 == 2));
      chk("t6_busy", 32'(busy2), 32'(c % 4 != 0));
      chk("t6_wr_idle", 32'({wr_ack2, MemWR2, mem_dq_oe2}), 32'b010);
      chk("t6_dq", 32'(mem_dq_out2), 0);
      if (c % 4 == 2) chk("t6_data", 32'(rd_data2), 32'(acc2[15:0] ^ 16'h5A5A));
      if (rd_ack2) begin
        chk("t6_adr", 32'(MemAdr2), 32'(rd_addr2));
        acc2 = rd_addr2; rd_addr2 = rd_addr2 + 26'd3;
        if (c >= 13) rd_req2 = 0;
      end
    end
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
